// File: rtl/fu_cdb_arbiter_pkg.sv
// Shared types and sizing for the ALU-result to CDB arbiter.
package fu_cdb_arbiter_pkg;

  localparam int unsigned NUM_FU_DEF  = 4;
  localparam int unsigned NUM_CDB_DEF = 2;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PREG_W      = 6;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] tag;
    logic [DATA_W-1:0] data;
  } cdb_packet_t;

  // Physical register 0 means "no writeback".
  function automatic logic tag_writes(input logic [PREG_W-1:0] tag);
    return tag != '0;
  endfunction

endpackage

// File: rtl/fu_cdb_arbiter_rr_grant.sv
// Round-robin multi-grant picker: grants the first NUM_CDB requests scanning from ptr_i.
module fu_cdb_arbiter_rr_grant #(
  parameter int unsigned NUM_FU  = 4,
  parameter int unsigned NUM_CDB = 2,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_FU-1:0]               req_i,
  input  logic [PTR_W-1:0]                ptr_i,
  output logic [NUM_FU-1:0]               grant_o,
  output logic [NUM_CDB-1:0][NUM_FU-1:0]  slot_sel_o,
  output logic [PTR_W-1:0]                last_idx_o,
  output logic                            any_grant_o
);

  int unsigned      cnt;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    slot_sel_o  = '0;
    last_idx_o  = '0;
    any_grant_o = 1'b0;
    cnt         = 0;
    sum         = '0;
    idx         = '0;
    for (int unsigned off = 0; off < NUM_FU; off++) begin
      // Modulo wrap without a divider; NUM_FU need not be a power of two.
      sum = {1'b0, ptr_i} + (PTR_W+1)'(off);
      if (sum >= (PTR_W+1)'(NUM_FU)) sum = sum - (PTR_W+1)'(NUM_FU);
      idx = sum[PTR_W-1:0];
      if (req_i[idx] && (cnt < NUM_CDB)) begin
        grant_o[idx] = 1'b1;
        for (int unsigned k = 0; k < NUM_CDB; k++) begin
          if (k == cnt) slot_sel_o[k][idx] = 1'b1;
        end
        last_idx_o  = idx;
        any_grant_o = 1'b1;
        cnt         = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// Per-ALU one-entry result holding registers shared onto NUM_CDB CDB ports round-robin.
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_FU  = NUM_FU_DEF,
  parameter int unsigned NUM_CDB = NUM_CDB_DEF
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        squash_i,
  input  logic [NUM_FU-1:0]           fu_valid_i,
  input  logic [NUM_FU*DATA_W-1:0]    fu_data_i,
  input  logic [NUM_FU*PREG_W-1:0]    fu_tag_i,
  output logic [NUM_FU-1:0]           fu_ready_o,
  output logic [NUM_CDB-1:0]          cdb_valid_o,
  output logic [NUM_CDB*DATA_W-1:0]   cdb_data_o,
  output logic [NUM_CDB*PREG_W-1:0]   cdb_tag_o
);

  localparam int unsigned PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  cdb_packet_t [NUM_FU-1:0]        hold_q, hold_d;
  cdb_packet_t [NUM_CDB-1:0]       cdb_pkt;
  logic [PTR_W-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0]               req, grant, load;
  logic [NUM_CDB-1:0][NUM_FU-1:0]  slot_sel;
  logic [PTR_W-1:0]                last_idx;
  logic                            any_grant;

  // Squash masks every request so nothing reaches the CDB in the flush cycle.
  always_comb begin
    req        = '0;
    load       = '0;
    fu_ready_o = '1;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      req[i] = hold_q[i].valid & ~squash_i;
      if (!squash_i) fu_ready_o[i] = ~hold_q[i].valid | grant[i];
      load[i] = fu_valid_i[i] & fu_ready_o[i] & ~squash_i
              & tag_writes(fu_tag_i[i*PREG_W +: PREG_W]);
    end
  end

  fu_cdb_arbiter_rr_grant #(
    .NUM_FU  (NUM_FU),
    .NUM_CDB (NUM_CDB),
    .PTR_W   (PTR_W)
  ) u_rr_grant (
    .req_i       (req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .slot_sel_o  (slot_sel),
    .last_idx_o  (last_idx),
    .any_grant_o (any_grant)
  );

  // Refill wins over dequeue so a granted entry can reload in the same cycle.
  always_comb begin
    hold_d = hold_q;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (squash_i) begin
        hold_d[i].valid = 1'b0;
      end else if (load[i]) begin
        hold_d[i].valid = 1'b1;
        hold_d[i].tag   = fu_tag_i[i*PREG_W +: PREG_W];
        hold_d[i].data  = fu_data_i[i*DATA_W +: DATA_W];
      end else if (grant[i]) begin
        hold_d[i].valid = 1'b0;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      rr_ptr_d = (last_idx == PTR_W'(NUM_FU - 1)) ? '0 : last_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      hold_q   <= hold_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // One-hot slot selects make the output mux a plain AND-OR.
  always_comb begin
    cdb_pkt     = '0;
    cdb_valid_o = '0;
    cdb_data_o  = '0;
    cdb_tag_o   = '0;
    for (int unsigned k = 0; k < NUM_CDB; k++) begin
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (slot_sel[k][i]) cdb_pkt[k] = cdb_pkt[k] | hold_q[i];
      end
      cdb_valid_o[k]                   = cdb_pkt[k].valid;
      cdb_data_o[k*DATA_W +: DATA_W]   = cdb_pkt[k].data;
      cdb_tag_o[k*PREG_W +: PREG_W]    = cdb_pkt[k].tag;
    end
  end

endmodule
